zap_btb_assoc: RTL and testbench
================================

ZAP_BTB_ASSOC -- requirements
Module: zap_btb_assoc

Interface
REQ-001 Parameter BP_SETS, default 512: number of sets; power of two, >= 2.
REQ-002 Parameter BP_WAYS, default 2: ways per set; legal values 1, 2, 4.
REQ-003 Parameter IDX_W = log2(BP_SETS); TAG_W = 31 - IDX_W (derived, not overridable).
REQ-004 Clock and reset: i_clk is the single clock; i_reset_n is a synchronous, active-low reset.
REQ-005 i_clk  in  1  clock.
REQ-006 i_reset_n  in  1  synchronous active-low reset.
REQ-007 i_stall  in  1  freezes the read pipeline.
REQ-008 i_clear  in  1  invalidates all entries.
REQ-009 i_fb_ok  in  1  feedback: prediction correct.
REQ-010 i_fb_nok  in  1  feedback: misprediction.
REQ-011 i_fb_branch_src_address  in  32  branch PC.
REQ-012 i_fb_current_branch_state  in  2  counter state used at prediction.
REQ-013 i_fb_branch_dest_address  in  32  resolved target.
REQ-014 i_rd_addr  in  32  fetch PC.
REQ-015 i_rd_addr_del  in  32  fetch PC delayed one unstalled cycle.
REQ-016 o_clear_from_btb  out  1  predicted-taken redirect.
REQ-017 o_pc_from_btb  out  32  predicted target.
REQ-018 o_state_from_btb  out  2  counter state of the hit entry.

Function
REQ-019 Index = addr[IDX_W:1]; tag = addr[IDX_W+TAG_W:IDX_W+1]; addr[0] is ignored.
REQ-020 Each way entry holds {target[31:0], tag, state[1:0]} plus a valid bit held in flops; each set holds a log2(BP_WAYS)-bit round-robin victim pointer.
REQ-021 Read: when i_stall=0, all ways of index(i_rd_addr) are read at edge N; the tag compare against i_rd_addr_del happens in cycle N+1; outputs register at edge N+1.
REQ-022 Hit = valid AND tag equal AND state in {WT, ST}; on a hit, o_clear_from_btb=1, o_pc_from_btb=target, o_state_from_btb=state; otherwise o_clear_from_btb=0 and o_pc_from_btb holds its value.
REQ-023 When multiple ways match, the lowest-numbered way wins.
REQ-024 When i_stall=1, the RAM read, the valid snapshot and all outputs hold.
REQ-025 Feedback write (i_fb_ok|i_fb_nok) takes one cycle; it searches the set of src for a tag match; on a match, that way is rewritten.
REQ-026 On a feedback miss, the victim is the lowest invalid way, else the victim pointer; the pointer then advances mod BP_WAYS.
REQ-027 Written state: ok -> SNT/WNT becomes SNT and WT/ST becomes ST; nok -> SNT becomes WNT, WNT becomes WT, WT becomes WNT, ST becomes WT.
REQ-028 Written target = i_fb_branch_dest_address; the valid bit is set.
REQ-029 i_clear clears all valid bits and o_clear_from_btb next edge regardless of i_stall; clear plus feedback in the same cycle: clear wins, no write.
REQ-030 A read and write to the same set in the same cycle returns pre-write data (no bypass).
REQ-031 i_fb_ok and i_fb_nok both high is treated as nok.

Reset
REQ-032 On i_reset_n=0 at an edge: all valid bits=0, victim pointers=0, o_clear_from_btb=0, o_pc_from_btb=0, o_state_from_btb=SNT; reset overrides stall, clear and feedback.
REQ-033 RAM contents are not reset; validity is governed only by the valid bits.

Configuration
REQ-034 Macro ZAP_BTB_STATS_EN: when defined, the block adds outputs o_stat_hits[31:0] (increments on each registered hit) and o_stat_mispredicts[31:0] (increments on each i_fb_nok); both saturate at 0xFFFFFFFF and are cleared only by reset.
REQ-035 When ZAP_BTB_STATS_EN is undefined, those ports and counters are absent and behaviour is otherwise identical.

Verification
REQ-036 Reset, then read 0x100 -> o_clear_from_btb=0 at all cycles, o_pc_from_btb=0.
REQ-037 fb_nok src=0x100, state=WNT, dest=0x2000; then read 0x100 -> o_clear_from_btb=1, o_pc_from_btb=0x2000, o_state_from_btb=WT two edges after the read.
REQ-038 With BP_WAYS=2, write srcs 0x100, 0x100+2*BP_SETS and 0x100+4*BP_SETS (same set) -> the third write evicts way0 (0x100); read 0x100 misses and the other two hit.
REQ-039 Hit established, i_stall=1 for 3 cycles while i_rd_addr changes -> outputs constant; i_clear pulsed during the stall -> o_clear_from_btb=0 next edge and a subsequent read 0x100 misses.
REQ-040 fb_ok and i_clear asserted in the same cycle, src=0x300 -> read 0x300 misses.
REQ-041 With ZAP_BTB_STATS_EN: 5 hits and 3 nok -> o_stat_hits=5, o_stat_mispredicts=3; counter preloaded to 0xFFFFFFFF stays there on a further hit.

Source files
------------

// File: rtl/zap_btb_assoc.sv
// ---------------------------------------------------------------------------
// zap_btb_assoc
//
// Set-associative branch target buffer with 2-bit saturating direction
// counters. A fetch address is looked up over two cycles: the set is read
// on the first edge, and the tag compare plus output registration happen
// on the second. Resolved branches train the buffer through a single-cycle
// feedback write that either rewrites a matching way or allocates a victim.
//
// Optional feature: define ZAP_BTB_STATS_EN to add saturating hit and
// misprediction counters (o_stat_hits, o_stat_mispredicts).
//
// Parameters
//   BP_SETS                    number of sets (power of two, >= 2)
//   BP_WAYS                    ways per set (1, 2 or 4)
//
// Ports
//   i_clk                      clock
//   i_reset_n                  synchronous active-low reset
//   i_stall                    freezes the read pipeline and the outputs
//   i_clear                    invalidates every entry
//   i_fb_ok / i_fb_nok         feedback strobes (correct / mispredicted)
//   i_fb_branch_src_address    PC of the resolved branch
//   i_fb_current_branch_state  counter state used when it was predicted
//   i_fb_branch_dest_address   resolved branch target
//   i_rd_addr                  fetch PC
//   i_rd_addr_del              fetch PC delayed by one unstalled cycle
//   o_clear_from_btb           predicted-taken redirect
//   o_pc_from_btb              predicted target
//   o_state_from_btb           counter state of the hit entry
//   o_stat_hits                (stats build) registered hit count
//   o_stat_mispredicts         (stats build) misprediction count
// ---------------------------------------------------------------------------
module zap_btb_assoc #(
  parameter int BP_SETS = 512,
  parameter int BP_WAYS = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_stall,
  input  logic        i_clear,
  input  logic        i_fb_ok,
  input  logic        i_fb_nok,
  input  logic [31:0] i_fb_branch_src_address,
  input  logic [1:0]  i_fb_current_branch_state,
  input  logic [31:0] i_fb_branch_dest_address,
  input  logic [31:0] i_rd_addr,
  input  logic [31:0] i_rd_addr_del,
`ifdef ZAP_BTB_STATS_EN
  output logic [31:0] o_stat_hits,
  output logic [31:0] o_stat_mispredicts,
`endif
  output logic        o_clear_from_btb,
  output logic [31:0] o_pc_from_btb,
  output logic [1:0]  o_state_from_btb
);

  localparam int IDX_W = $clog2(BP_SETS);
  localparam int TAG_W = 31 - IDX_W;
  localparam int PTR_W = (BP_WAYS > 1) ? $clog2(BP_WAYS) : 1;

  // Counter encoding: the upper bit alone means "predict taken".
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Storage: payload arrays are not reset; validity lives in flops.
  logic [31:0]        tgt_mem [BP_WAYS][BP_SETS];
  logic [TAG_W-1:0]   tag_mem [BP_WAYS][BP_SETS];
  logic [1:0]         st_mem  [BP_WAYS][BP_SETS];
  logic [BP_WAYS-1:0] valid_q  [BP_SETS];
  logic [PTR_W-1:0]   victim_q [BP_SETS];

  // First read stage: snapshot of every way of the addressed set.
  logic [31:0]        rd_tgt_q [BP_WAYS];
  logic [TAG_W-1:0]   rd_tag_q [BP_WAYS];
  logic [1:0]         rd_st_q  [BP_WAYS];
  logic [BP_WAYS-1:0] rd_valid_q;

  logic               clear_q;
  logic [31:0]        pc_q;
  logic [1:0]         state_q;

  logic [IDX_W-1:0]   rd_idx;
  logic [TAG_W-1:0]   del_tag;
  logic [IDX_W-1:0]   fb_idx;
  logic [TAG_W-1:0]   fb_tag;

  logic               fb_req;
  logic               fb_we;
  logic               fb_hit;
  logic [PTR_W-1:0]   fb_hit_way;
  logic               fb_inv;
  logic [PTR_W-1:0]   fb_inv_way;
  logic [PTR_W-1:0]   fb_way_d;
  logic [1:0]         fb_state_d;
  logic [PTR_W-1:0]   victim_d;

  logic               rd_hit;
  logic [31:0]        rd_hit_tgt;
  logic [1:0]         rd_hit_st;

  logic               unused_bits;

  assign rd_idx  = i_rd_addr[IDX_W:1];
  assign del_tag = i_rd_addr_del[IDX_W+TAG_W:IDX_W+1];
  assign fb_idx  = i_fb_branch_src_address[IDX_W:1];
  assign fb_tag  = i_fb_branch_src_address[IDX_W+TAG_W:IDX_W+1];

  // Bit 0 of every address is a halfword offset and carries no information.
  assign unused_bits = ^{i_rd_addr[0], i_rd_addr[IDX_W+TAG_W:IDX_W+1],
                         i_rd_addr_del[IDX_W:0], i_fb_branch_src_address[0]};

  // A simultaneous clear discards the feedback write entirely.
  assign fb_req = i_fb_ok | i_fb_nok;
  assign fb_we  = fb_req & ~i_clear;

  // Feedback set search. Scanning from the top way down lets the lowest
  // matching (or lowest invalid) way be the one left standing.
  always_comb begin
    fb_hit     = 1'b0;
    fb_hit_way = '0;
    fb_inv     = 1'b0;
    fb_inv_way = '0;
    for (int w = BP_WAYS - 1; w >= 0; w--) begin
      if (valid_q[fb_idx][w] && (tag_mem[w][fb_idx] == fb_tag)) begin
        fb_hit     = 1'b1;
        fb_hit_way = PTR_W'(w);
      end
      if (!valid_q[fb_idx][w]) begin
        fb_inv     = 1'b1;
        fb_inv_way = PTR_W'(w);
      end
    end
  end

  // Way selection: matching way, else lowest invalid, else round-robin.
  always_comb begin
    fb_way_d = victim_q[fb_idx];
    if (fb_hit) begin
      fb_way_d = fb_hit_way;
    end else if (fb_inv) begin
      fb_way_d = fb_inv_way;
    end
    victim_d = (BP_WAYS == 1) ? '0 : victim_q[fb_idx] + 1'b1;
  end

  // Counter training. Misprediction takes priority when both strobes fire.
  // A correct prediction saturates toward whichever direction was predicted.
  always_comb begin
    fb_state_d = i_fb_current_branch_state[1] ? ST : SNT;
    if (i_fb_nok) begin
      case (i_fb_current_branch_state)
        SNT:     fb_state_d = WNT;
        WNT:     fb_state_d = WT;
        WT:      fb_state_d = WNT;
        default: fb_state_d = WT;
      endcase
    end
  end

  // Payload write port; reset blocks it but never initialises contents.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && fb_we) begin
      tgt_mem[fb_way_d][fb_idx] <= i_fb_branch_dest_address;
      tag_mem[fb_way_d][fb_idx] <= fb_tag;
      st_mem[fb_way_d][fb_idx]  <= fb_state_d;
    end
  end

  // Valid bits and victim pointers. The pointer only moves when a new
  // entry is allocated, not when an existing entry is retrained.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int s = 0; s < BP_SETS; s++) begin
        valid_q[s]  <= '0;
        victim_q[s] <= '0;
      end
    end else if (i_clear) begin
      for (int s = 0; s < BP_SETS; s++) begin
        valid_q[s] <= '0;
      end
    end else if (fb_we) begin
      valid_q[fb_idx][fb_way_d] <= 1'b1;
      if (!fb_hit) begin
        victim_q[fb_idx] <= victim_d;
      end
    end
  end

  // First read stage. Reading registered arrays gives pre-write data when
  // a feedback write hits the same set on the same edge.
  always_ff @(posedge i_clk) begin
    if (!i_stall) begin
      for (int w = 0; w < BP_WAYS; w++) begin
        rd_tgt_q[w] <= tgt_mem[w][rd_idx];
        rd_tag_q[w] <= tag_mem[w][rd_idx];
        rd_st_q[w]  <= st_mem[w][rd_idx];
      end
    end
  end

  // The valid snapshot is also wiped by a clear so that a read captured
  // before a clear cannot produce a stale hit once a stall releases.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rd_valid_q <= '0;
    end else if (i_clear) begin
      rd_valid_q <= '0;
    end else if (!i_stall) begin
      rd_valid_q <= valid_q[rd_idx];
    end
  end

  // Second stage compare; only taken-predicting counters count as a hit.
  always_comb begin
    rd_hit     = 1'b0;
    rd_hit_tgt = '0;
    rd_hit_st  = SNT;
    for (int w = BP_WAYS - 1; w >= 0; w--) begin
      if (rd_valid_q[w] && (rd_tag_q[w] == del_tag) && rd_st_q[w][1]) begin
        rd_hit     = 1'b1;
        rd_hit_tgt = rd_tgt_q[w];
        rd_hit_st  = rd_st_q[w];
      end
    end
  end

  // Output registers. The target and state hold across misses so the
  // fetch unit always sees the last prediction made.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      clear_q <= 1'b0;
      pc_q    <= '0;
      state_q <= SNT;
    end else if (i_clear) begin
      clear_q <= 1'b0;
    end else if (!i_stall) begin
      clear_q <= rd_hit;
      if (rd_hit) begin
        pc_q    <= rd_hit_tgt;
        state_q <= rd_hit_st;
      end
    end
  end

  assign o_clear_from_btb = clear_q;
  assign o_pc_from_btb    = pc_q;
  assign o_state_from_btb = state_q;

`ifdef ZAP_BTB_STATS_EN
  logic [31:0] stat_hits_q;
  logic [31:0] stat_mis_q;

  // Saturating event counters; a hit counts when the output register
  // actually captures it.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      stat_hits_q <= '0;
      stat_mis_q  <= '0;
    end else begin
      if (!i_clear && !i_stall && rd_hit && (stat_hits_q != 32'hFFFF_FFFF)) begin
        stat_hits_q <= stat_hits_q + 32'd1;
      end
      if (i_fb_nok && (stat_mis_q != 32'hFFFF_FFFF)) begin
        stat_mis_q <= stat_mis_q + 32'd1;
      end
    end
  end

  assign o_stat_hits        = stat_hits_q;
  assign o_stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_zap_btb_assoc.sv
// ---------------------------------------------------------------------------
// tb_zap_btb_assoc
//
// Directed testbench for zap_btb_assoc with the default geometry
// (512 sets, 2 ways). Each scenario task drives stimulus and checks the
// registered outputs one time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_zap_btb_assoc;

  localparam int SETS = 512;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_stall;
  logic        i_clear;
  logic        i_fb_ok;
  logic        i_fb_nok;
  logic [31:0] i_fb_branch_src_address;
  logic [1:0]  i_fb_current_branch_state;
  logic [31:0] i_fb_branch_dest_address;
  logic [31:0] i_rd_addr;
  logic [31:0] i_rd_addr_del;
  logic        o_clear_from_btb;
  logic [31:0] o_pc_from_btb;
  logic [1:0]  o_state_from_btb;
`ifdef ZAP_BTB_STATS_EN
  logic [31:0] o_stat_hits;
  logic [31:0] o_stat_mispredicts;
`endif

  int testsRun;
  int testsFailed;

  zap_btb_assoc #(.BP_SETS(SETS), .BP_WAYS(2)) dut (
    .i_clk                     (i_clk),
    .i_reset_n                 (i_reset_n),
    .i_stall                   (i_stall),
    .i_clear                   (i_clear),
    .i_fb_ok                   (i_fb_ok),
    .i_fb_nok                  (i_fb_nok),
    .i_fb_branch_src_address   (i_fb_branch_src_address),
    .i_fb_current_branch_state (i_fb_current_branch_state),
    .i_fb_branch_dest_address  (i_fb_branch_dest_address),
    .i_rd_addr                 (i_rd_addr),
    .i_rd_addr_del             (i_rd_addr_del),
`ifdef ZAP_BTB_STATS_EN
    .o_stat_hits               (o_stat_hits),
    .o_stat_mispredicts        (o_stat_mispredicts),
`endif
    .o_clear_from_btb          (o_clear_from_btb),
    .o_pc_from_btb             (o_pc_from_btb),
    .o_state_from_btb          (o_state_from_btb)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one edge; the delayed fetch PC follows the PC seen at that
  // edge whenever the pipeline was not stalled.
  task automatic tick();
    @(posedge i_clk);
    #1;
    if (!i_stall) i_rd_addr_del = i_rd_addr;
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    tick();
    tick();
    i_reset_n = 1'b1;
  endtask

  task automatic feedback(input logic ok, input logic nok, input logic [31:0] src,
                          input logic [1:0] st, input logic [31:0] dest);
    i_fb_ok = ok;
    i_fb_nok = nok;
    i_fb_branch_src_address = src;
    i_fb_current_branch_state = st;
    i_fb_branch_dest_address = dest;
    tick();
    i_fb_ok = 1'b0;
    i_fb_nok = 1'b0;
  endtask

  // Present a fetch PC long enough for its lookup to reach the outputs.
  task automatic do_read(input logic [31:0] addr);
    i_rd_addr = addr;
    tick();
    tick();
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    i_stall = 1'b1;
    i_clear = 1'b1;
    i_fb_nok = 1'b1;
    tick();
    tick();
    i_stall = 1'b0;
    i_clear = 1'b0;
    i_fb_nok = 1'b0;
    testsRun++;
    if (o_clear_from_btb !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_clear got %0b want 0", o_clear_from_btb);
    end
    testsRun++;
    if (o_pc_from_btb !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_pc got %h want 00000000", o_pc_from_btb);
    end
    testsRun++;
    if (o_state_from_btb !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL reset_state got %0d want 0", o_state_from_btb);
    end
    i_reset_n = 1'b1;
  endtask

  task automatic test_cold_miss();
    i_rd_addr = 32'h100;
    for (int c = 0; c < 3; c++) begin
      tick();
      testsRun++;
      if (o_clear_from_btb !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL cold_clear cycle %0d got %0b want 0", c, o_clear_from_btb);
      end
    end
    testsRun++;
    if (o_pc_from_btb !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL cold_pc got %h want 00000000", o_pc_from_btb);
    end
  endtask

  task automatic test_write_hit();
    feedback(1'b0, 1'b1, 32'h100, 2'b01, 32'h2000);
    i_rd_addr = 32'h100;
    tick();
    testsRun++;
    if (o_clear_from_btb !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL hit_latency got %0b want 0 one edge after read", o_clear_from_btb);
    end
    tick();
    testsRun++;
    if (o_clear_from_btb !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL hit_clear got %0b want 1", o_clear_from_btb);
    end
    testsRun++;
    if (o_pc_from_btb !== 32'h2000) begin
      testsFailed++;
      $display("[TB] FAIL hit_pc got %h want 00002000", o_pc_from_btb);
    end
    testsRun++;
    if (o_state_from_btb !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL hit_state got %0d want 2", o_state_from_btb);
    end
  endtask

  task automatic test_state_update();
    feedback(1'b1, 1'b0, 32'h100, 2'b10, 32'h2000);
    do_read(32'h100);
    testsRun++;
    if (o_clear_from_btb !== 1'b1 || o_state_from_btb !== 2'b11) begin
      testsFailed++;
      $display("[TB] FAIL ok_wt_to_st got clear=%0b state=%0d want clear=1 state=3",
               o_clear_from_btb, o_state_from_btb);
    end
    feedback(1'b1, 1'b0, 32'h100, 2'b01, 32'h2000);
    do_read(32'h100);
    testsRun++;
    if (o_clear_from_btb !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL ok_wnt_to_snt got clear=%0b want 0", o_clear_from_btb);
    end
  endtask

  task automatic test_nok_transitions();
    feedback(1'b0, 1'b1, 32'h100, 2'b00, 32'h2000);
    do_read(32'h100);
    testsRun++;
    if (o_clear_from_btb !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL nok_snt_to_wnt got clear=%0b want 0", o_clear_from_btb);
    end
    feedback(1'b0, 1'b1, 32'h100, 2'b11, 32'h2222);
    do_read(32'h100);
    testsRun++;
    if (o_clear_from_btb !== 1'b1 || o_state_from_btb !== 2'b10 || o_pc_from_btb !== 32'h2222) begin
      testsFailed++;
      $display("[TB] FAIL nok_st_to_wt got clear=%0b state=%0d pc=%h want clear=1 state=2 pc=00002222",
               o_clear_from_btb, o_state_from_btb, o_pc_from_btb);
    end
    feedback(1'b0, 1'b1, 32'h100, 2'b10, 32'h2222);
    do_read(32'h100);
    testsRun++;
    if (o_clear_from_btb !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL nok_wt_to_wnt got clear=%0b want 0", o_clear_from_btb);
    end
  endtask

  task automatic test_eviction();
    do_reset();
    i_rd_addr = 32'h0;
    feedback(1'b0, 1'b1, 32'h100,            2'b01, 32'hA000);
    feedback(1'b0, 1'b1, 32'h100 + 2 * SETS, 2'b01, 32'hB000);
    feedback(1'b0, 1'b1, 32'h100 + 4 * SETS, 2'b01, 32'hC000);
    do_read(32'h100);
    testsRun++;
    if (o_clear_from_btb !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL evict_way0 got clear=%0b want 0", o_clear_from_btb);
    end
    do_read(32'h100 + 2 * SETS);
    testsRun++;
    if (o_clear_from_btb !== 1'b1 || o_pc_from_btb !== 32'hB000) begin
      testsFailed++;
      $display("[TB] FAIL evict_keep_b got clear=%0b pc=%h want clear=1 pc=0000b000",
               o_clear_from_btb, o_pc_from_btb);
    end
    do_read(32'h100 + 4 * SETS);
    testsRun++;
    if (o_clear_from_btb !== 1'b1 || o_pc_from_btb !== 32'hC000) begin
      testsFailed++;
      $display("[TB] FAIL evict_new_c got clear=%0b pc=%h want clear=1 pc=0000c000",
               o_clear_from_btb, o_pc_from_btb);
    end
  endtask

  task automatic test_update_in_place();
    feedback(1'b0, 1'b1, 32'h100 + 2 * SETS, 2'b01, 32'hD000);
    do_read(32'h100 + 2 * SETS);
    testsRun++;
    if (o_clear_from_btb !== 1'b1 || o_pc_from_btb !== 32'hD000) begin
      testsFailed++;
      $display("[TB] FAIL rewrite_pc got clear=%0b pc=%h want clear=1 pc=0000d000",
               o_clear_from_btb, o_pc_from_btb);
    end
    do_read(32'h100 + 4 * SETS);
    testsRun++;
    if (o_clear_from_btb !== 1'b1 || o_pc_from_btb !== 32'hC000) begin
      testsFailed++;
      $display("[TB] FAIL rewrite_keep_c got clear=%0b pc=%h want clear=1 pc=0000c000",
               o_clear_from_btb, o_pc_from_btb);
    end
  endtask

  task automatic test_stall_clear();
    logic [31:0] addrs [3];
    addrs[0] = 32'h100;
    addrs[1] = 32'h0;
    addrs[2] = 32'h100 + 4 * SETS;
    do_read(32'h100 + 2 * SETS);
    i_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      i_rd_addr = addrs[c];
      tick();
      testsRun++;
      if (o_clear_from_btb !== 1'b1 || o_pc_from_btb !== 32'hD000 || o_state_from_btb !== 2'b10) begin
        testsFailed++;
        $display("[TB] FAIL stall_hold cycle %0d got clear=%0b pc=%h state=%0d want 1 0000d000 2",
                 c, o_clear_from_btb, o_pc_from_btb, o_state_from_btb);
      end
    end
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    testsRun++;
    if (o_clear_from_btb !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL stall_clear got clear=%0b want 0", o_clear_from_btb);
    end
    i_stall = 1'b0;
    do_read(32'h100 + 2 * SETS);
    testsRun++;
    if (o_clear_from_btb !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL after_clear_b got clear=%0b want 0", o_clear_from_btb);
    end
    do_read(32'h100 + 4 * SETS);
    testsRun++;
    if (o_clear_from_btb !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL after_clear_c got clear=%0b want 0", o_clear_from_btb);
    end
  endtask

  task automatic test_clear_vs_fb();
    i_clear = 1'b1;
    feedback(1'b1, 1'b0, 32'h300, 2'b10, 32'h3000);
    i_clear = 1'b0;
    do_read(32'h300);
    testsRun++;
    if (o_clear_from_btb !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL clear_wins got clear=%0b want 0", o_clear_from_btb);
    end
    feedback(1'b1, 1'b0, 32'h300, 2'b10, 32'h3000);
    do_read(32'h300);
    testsRun++;
    if (o_clear_from_btb !== 1'b1 || o_pc_from_btb !== 32'h3000 || o_state_from_btb !== 2'b11) begin
      testsFailed++;
      $display("[TB] FAIL fb_alone got clear=%0b pc=%h state=%0d want 1 00003000 3",
               o_clear_from_btb, o_pc_from_btb, o_state_from_btb);
    end
  endtask

  task automatic test_ok_and_nok();
    feedback(1'b1, 1'b1, 32'h700, 2'b01, 32'h7000);
    do_read(32'h700);
    testsRun++;
    if (o_clear_from_btb !== 1'b1 || o_pc_from_btb !== 32'h7000 || o_state_from_btb !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL ok_nok_as_nok got clear=%0b pc=%h state=%0d want 1 00007000 2",
               o_clear_from_btb, o_pc_from_btb, o_state_from_btb);
    end
  endtask

  task automatic test_same_cycle_rw();
    i_rd_addr = 32'h180;
    feedback(1'b0, 1'b1, 32'h180, 2'b01, 32'h4000);
    tick();
    testsRun++;
    if (o_clear_from_btb !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL no_bypass got clear=%0b want 0", o_clear_from_btb);
    end
    tick();
    testsRun++;
    if (o_clear_from_btb !== 1'b1 || o_pc_from_btb !== 32'h4000) begin
      testsFailed++;
      $display("[TB] FAIL after_write got clear=%0b pc=%h want clear=1 pc=00004000",
               o_clear_from_btb, o_pc_from_btb);
    end
  endtask

`ifdef ZAP_BTB_STATS_EN
  task automatic test_stats();
    i_rd_addr = 32'h0;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      feedback(1'b0, 1'b1, 32'h100, 2'b01, 32'h2000);
    end
    i_rd_addr = 32'h100;
    for (int n = 0; n < 5; n++) tick();
    i_rd_addr = 32'h0;
    tick();
    tick();
    testsRun++;
    if (o_stat_hits !== 32'd5) begin
      testsFailed++;
      $display("[TB] FAIL stat_hits got %0d want 5", o_stat_hits);
    end
    testsRun++;
    if (o_stat_mispredicts !== 32'd3) begin
      testsFailed++;
      $display("[TB] FAIL stat_mispredicts got %0d want 3", o_stat_mispredicts);
    end
    dut.stat_hits_q = 32'hFFFF_FFFF;
    i_rd_addr = 32'h100;
    tick();
    tick();
    tick();
    testsRun++;
    if (o_stat_hits !== 32'hFFFF_FFFF) begin
      testsFailed++;
      $display("[TB] FAIL stat_saturate got %h want ffffffff", o_stat_hits);
    end
  endtask
`endif

  initial begin
    testsRun = 0;
    testsFailed = 0;
    i_reset_n = 1'b0;
    i_stall = 1'b0;
    i_clear = 1'b0;
    i_fb_ok = 1'b0;
    i_fb_nok = 1'b0;
    i_fb_branch_src_address = 32'h0;
    i_fb_current_branch_state = 2'b00;
    i_fb_branch_dest_address = 32'h0;
    i_rd_addr = 32'h0;
    i_rd_addr_del = 32'h0;

    test_reset();
    test_cold_miss();
    test_write_hit();
    test_state_update();
    test_nok_transitions();
    test_eviction();
    test_update_in_place();
    test_stall_clear();
    test_clear_vs_fb();
    test_ok_and_nok();
    test_same_cycle_rw();
`ifdef ZAP_BTB_STATS_EN
    test_stats();
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
